uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the CPU data bus, downstream of the CPU's mem_addr/mem_wdata/mem_wstrb/mem_rstrb outputs.
- Stores to TXDATA push bytes into a small FIFO. A serial FSM drains the FIFO as 8N1 frames.
- Loads return status and baud configuration on mem_rdata one cycle after mem_rstrb, matching the CPU's one-cycle read timing.

---
 rtl/uart_tx_mmio_pkg.sv | 12 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/uart_tx_mmio.sv | 122 ++++++++++++
 tb/tb_uart_tx_mmio.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: register offsets, STATUS bit positions and TX FSM encoding shared by the UART transmitter
package uart_tx_mmio_pkg;
  localparam logic [3:0] TXDATA_OFS  = 4'h0;
  localparam logic [3:0] STATUS_OFS  = 4'h4;
  localparam logic [3:0] BAUDDIV_OFS = 4'h8;
  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; push while full is only accepted when a pop frees a slot in the same cycle
//   clk, rst (async, active-low) | push, din -> write side | pop, dout -> read side (dout = head)
//   full, empty, count -> occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  // An empty FIFO never bypasses: the pushed byte is stored and the pop is ignored.
  assign do_push = push & (~full | do_pop);
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO, status and baud divider registers
//   clk, rst (async, active-low)
//   mem_addr, mem_wdata, mem_wstrb, mem_rstrb -> CPU bus inputs
//   mem_rdata -> registered read data (0 when not selected), sel -> combinational window hit
//   tx -> serial line (idle high), irq -> FIFO empty and shifter idle
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d, tmr_q, tmr_d, div_m1;
  logic [7:0] shift_q, shift_d, fifo_dout;
  logic [2:0] bit_q, bit_d;
  logic ovf_q, ovf_d, irq_q, irq_d, tx_q, tx_d;
  logic [31:0] rdata_q, rdata_d, status;
  logic push, pop, pop_ok, push_ok, full, empty, rd_en, baud_wr, stat_rd;
  logic [CW-1:0] count, cnt_n;
  logic [3:0] ofs, cnt_sat;
  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};
  assign sel = mem_addr[31:4] == BASE_ADDR[31:4];
  assign ofs = {mem_addr[3:2], 2'b00};
  // Only byte lane 0 pushes, so a multi-cycle word store to TXDATA enqueues exactly once.
  assign push = sel && ofs == TXDATA_OFS && mem_wstrb[0];
  assign baud_wr = sel && ofs == BAUDDIV_OFS;
  assign rd_en = mem_rstrb & sel;
  assign stat_rd = rd_en && ofs == STATUS_OFS;
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign cnt_n = count + CW'(push_ok) - CW'(pop_ok);
  assign cnt_sat = 32'(count) > 32'd15 ? 4'hF : 4'(count);
  assign div_m1 = baud_q == '0 ? 16'd0 : baud_q - 16'd1;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(mem_wdata[7:0]),
    .dout(fifo_dout), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    status = '0;
    status[ST_BUSY] = state_q != S_IDLE;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = ovf_q;
    status[ST_CNT_LSB +: 4] = cnt_sat;
    rdata_d = !rd_en ? 32'd0 : ofs == STATUS_OFS ? status : ofs == BAUDDIV_OFS ? {16'd0, baud_q} : 32'd0;
    // A STATUS read reports the old ovf and clears it; a new overflow on the same edge wins.
    ovf_d = (ovf_q & ~stat_rd) | (push & full & ~pop_ok);
    baud_d = {baud_wr && mem_wstrb[1] ? mem_wdata[15:8] : baud_q[15:8],
              baud_wr && mem_wstrb[0] ? mem_wdata[7:0] : baud_q[7:0]};
  end
  // The timer counts a bit period down to zero and is reloaded from BAUDDIV at each bit boundary.
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    if (state_q == S_IDLE) begin
      if (!empty) begin
        pop = 1'b1;
        shift_d = fifo_dout;
        tmr_d = div_m1;
        bit_d = 3'd0;
        state_d = S_START;
      end
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - 16'd1;
    end else begin
      tmr_d = div_m1;
      case (state_q)
        S_START: state_d = S_DATA;
        S_DATA: begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? S_STOP : S_DATA;
        end
        default: state_d = S_IDLE;
      endcase
    end
    tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : 1'b1;
    irq_d = cnt_n == '0 && state_d == S_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      tmr_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      baud_q <= BAUD_DIV_RST;
      ovf_q <= 1'b0;
      irq_q <= 1'b1;
      tx_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      baud_q <= baud_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      tx_q <= tx_d;
      rdata_q <= rdata_d;
    end
  assign tx = tx_q;
  assign irq = irq_q;
  assign mem_rdata = rdata_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized self-checking bench with a UART line decoder and a frame-timing reference model
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [3:0] STRB [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1111};
  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic mem_rstrb, sel, tx, irq;

  uart_tx_mmio dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .sel(sel), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic tx_log [16384];
  logic irq_log [16384];
  always @(negedge clk) begin
    tx_log[cyc % 16384] <= tx;
    irq_log[cyc % 16384] <= irq;
  end

  int n_chk = 0, n_pass = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Line decoder: samples each bit in the middle of its period at the current divider.
  int cur_div = 1;
  logic [7:0] rx_q [$];
  int rx_t [$];
  int rx_bad = 0;
  bit aborted = 0;
  logic [7:0] m_b;
  bit m_ok;
  int m_t0;
  initial forever begin
    @(negedge rst);
    aborted = 1;
  end
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1 && tx === 1'b0) begin
      m_t0 = cyc;
      aborted = 0;
      m_ok = 1;
      repeat (cur_div / 2) @(negedge clk);
      if (tx !== 1'b0) m_ok = 0;
      for (int i = 0; i < 8; i++) begin
        repeat (cur_div) @(negedge clk);
        m_b[i] = tx;
      end
      repeat (cur_div) @(negedge clk);
      if (tx !== 1'b1) m_ok = 0;
      repeat (cur_div - cur_div / 2 - 1) @(negedge clk);
      if (!aborted) begin
        rx_q.push_back(m_b);
        rx_t.push_back(m_t0);
        if (!m_ok) rx_bad++;
      end
    end
  end

  // Reference model: a byte accepted at the end of cycle p starts at p+2, or one idle cycle
  // after the previous 10-bit frame, whichever is later.
  logic [7:0] exp_q [$];
  int exp_t [$];
  task automatic expect_byte(logic [7:0] b, int push_cyc);
    int s = push_cyc + 2;
    if (exp_t.size() > 0 && exp_t[$] + 10 * cur_div + 1 > s) s = exp_t[$] + 10 * cur_div + 1;
    exp_q.push_back(b);
    exp_t.push_back(s);
  endtask

  task automatic drain_and_compare(string tag, int budget);
    int n = 0;
    while (rx_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (12 * cur_div + 4) @(negedge clk);
    check({tag, "_frames"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      check($sformatf("%s_start%0d", tag, i), rx_t[i], exp_t[i]);
    end
    check({tag, "_framing"}, rx_bad, 0);
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    exp_t.delete();
    rx_bad = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    @(posedge clk);
    #1;
    mem_wstrb = 4'h0;
  endtask

  task automatic bus_read(logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    mem_rstrb = 1'b1;
    @(posedge clk);
    #1;
    d = mem_rdata;
    mem_rstrb = 1'b0;
  endtask

  task automatic set_div(logic [15:0] v);
    bus_write(BASE + 8, {16'hDEAD, v}, 4'b0001);
    bus_write(BASE + 8, {16'hBEEF, v}, 4'b0010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, w;
    logic [7:0] pat;
    logic [3:0] s;
    logic e;
    int k, kk, bad, ibad, dv, n;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    mem_rstrb = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_irq", irq, 1);
    check("rst_rdata", mem_rdata, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus_read(BASE + 4, rd);
    check("status_reset", rd, 32'h4);
    bus_read(BASE + 8, rd);
    check("baud_reset", rd, 434);

    set_div(16'hA5C3);
    bus_write(BASE + 8, 32'h0000_7777, 4'b0100);
    bus_write(BASE + 12, 32'h0000_1111, 4'b1111);
    mem_addr = BASE + 8;
    mem_rstrb = 1'b1;
    #1;
    check("sel_in", sel, 1);
    check("rd_before_edge", mem_rdata, 0);
    @(posedge clk);
    #1;
    check("rd_latency", mem_rdata, 32'h0000_A5C3);
    mem_rstrb = 1'b0;
    @(posedge clk);
    #1;
    check("rd_no_strobe", mem_rdata, 0);
    mem_addr = BASE + 16;
    #1;
    check("sel_above", sel, 0);
    mem_addr = BASE - 4;
    #1;
    check("sel_below", sel, 0);
    bus_read(BASE + 16, rd);
    check("rd_outside", rd, 0);
    bus_read(BASE + 12, rd);
    check("rd_reserved", rd, 0);
    bus_read(BASE, rd);
    check("rd_txdata", rd, 0);
    bus_write(BASE + 16, 32'h99, 4'b0001);
    bus_write(BASE + 4, 32'h99, 4'b0001);
    bus_read(BASE + 4, rd);
    check("no_push_outside", rd, 32'h4);

    set_div(16'd4);
    cur_div = 4;
    k = cyc;
    bus_write(BASE, 32'h1234_5655, 4'b0001);
    bus_write(BASE, 32'h1234_5655, 4'b0010);
    bus_write(BASE, 32'h1234_5655, 4'b0100);
    bus_write(BASE, 32'h1234_5655, 4'b1000);
    expect_byte(8'h55, k);
    repeat (45) @(posedge clk);
    #1;
    pat = 8'h55;
    bad = 0;
    ibad = 0;
    for (int i = 0; i < 40; i++) begin
      e = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : pat[(i - 4) / 4];
      if (tx_log[(k + 2 + i) % 16384] !== e) bad++;
      if (irq_log[(k + 2 + i) % 16384] !== 1'b0) ibad++;
    end
    check("single_wave_bad_cycles", bad, 0);
    check("single_irq_low_bad_cycles", ibad, 0);
    check("single_irq_end", irq_log[(k + 42) % 16384], 1);
    check("single_tx_end", tx_log[(k + 42) % 16384], 1);
    drain_and_compare("single", 200);

    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(0, 6);
      set_div(dv[15:0]);
      cur_div = (dv == 0) ? 1 : dv;
      n = 0;
      for (int j = 0; j < 10; j++) begin
        s = STRB[$urandom_range(0, 5)];
        w = $urandom;
        if (s[0] && n >= 8) s = 4'b0010;
        kk = cyc;
        bus_write(BASE, w, s);
        if (s[0]) begin
          expect_byte(w[7:0], kk);
          n++;
        end
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      drain_and_compare($sformatf("rand%0d", it), 1000);
      check($sformatf("rand%0d_irq", it), irq, 1);
      bus_read(BASE + 4, rd);
      check($sformatf("rand%0d_status", it), rd, 32'h4);
    end

    set_div(16'd100);
    cur_div = 100;
    k = cyc;
    for (int j = 0; j < 10; j++) begin
      kk = cyc;
      bus_write(BASE, 32'hA0 + j, 4'b0001);
      if (j < 9) expect_byte(8'(32'hA0 + j), kk);
    end
    bus_read(BASE + 4, rd);
    check("ovf_status", rd, 32'h8B);
    bus_read(BASE + 4, rd);
    check("ovf_cleared", rd, 32'h83);
    while (cyc < k + 1002) begin
      @(posedge clk);
      #1;
    end
    kk = cyc;
    bus_write(BASE, 32'hEE, 4'b0001);
    expect_byte(8'hEE, kk);
    bus_read(BASE + 4, rd);
    check("full_pop_status", rd, 32'h83);
    check("full_pop_irq", irq, 0);
    drain_and_compare("ovf", 11000);

    set_div(16'd4);
    cur_div = 4;
    k = cyc;
    bus_write(BASE, 32'hF7, 4'b0001);
    bus_write(BASE, 32'h5A, 4'b0001);
    bus_write(BASE, 32'h66, 4'b0001);
    while (cyc < k + 19) @(negedge clk);
    #2;
    check("pre_abort_tx", tx, 0);
    rst = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_irq", irq, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus_read(BASE + 4, rd);
    check("abort_status", rd, 32'h4);
    bus_read(BASE + 8, rd);
    check("abort_baud", rd, 434);
    repeat (200) @(posedge clk);
    #1;
    check("abort_no_residual", rx_q.size(), 0);
    check("abort_tx_idle", tx, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
